// File: rtl/alarm_ringer.sv
// Alarm ring sequencer: turns a comparator match edge into a timed ring with
// beeping buzzer, status LED, snooze, stop and auto-timeout.
//
// state  | meaning
// IDLE   | waiting for an armed match rising edge
// RING   | buzzer beeping on beat, counting ticks toward timeout
// SNOOZE | silent, LED blinking per tick, counting ticks back to RING
// DONE   | sequence over, waiting for the match window to close or disarm
module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CNT_W       = 9,
  parameter int SNZ_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             beat,
  input  logic             alarm_en,
  input  logic             match,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic             buzz,
  output logic             alarm_led,
  output logic             ringing,
  output logic [SNZ_W-1:0] snooze_left,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RING_TC   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_TC = CNT_W'(SNOOZE_SECS - 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [SNZ_W-1:0] snz_nxt;
  logic             phase, phase_nxt;
  logic             blink, blink_nxt;
  logic             match_d;
  logic             match_rise;

  assign match_rise = match & ~match_d;
  assign state_dbg  = state;

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    snz_nxt     = snooze_left;
    phase_nxt   = phase;
    blink_nxt   = blink;
    case (state)
      IDLE: begin
        if (alarm_en && match_rise) begin
          state_nxt   = RING;
          counter_nxt = '0;
          snz_nxt     = SNZ_MAX;
          phase_nxt   = 1'b1;
        end
      end
      RING: begin
        if (beat) phase_nxt = ~phase;
        if (!alarm_en) begin
          state_nxt = IDLE;
        end else if (stop_btn) begin
          state_nxt = DONE;
        end else if (snooze_btn && snooze_left != '0) begin
          state_nxt   = SNOOZE;
          counter_nxt = '0;
          snz_nxt     = snooze_left - 1'b1;
          blink_nxt   = 1'b1;
        end else if (tick) begin
          // a snooze press with no snoozes left falls through to normal timing
          if (counter == RING_TC) state_nxt = DONE;
          else                    counter_nxt = counter + 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarm_en) begin
          state_nxt = IDLE;
        end else if (stop_btn) begin
          state_nxt = DONE;
        end else if (tick) begin
          if (counter == SNOOZE_TC) begin
            state_nxt   = RING;
            counter_nxt = '0;
            phase_nxt   = 1'b1;
          end else begin
            counter_nxt = counter + 1'b1;
            blink_nxt   = ~blink;
          end
        end
      end
      DONE: begin
        if (!alarm_en || !match) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are formed from next-state values so they move with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      snooze_left <= '0;
      phase       <= 1'b0;
      blink       <= 1'b0;
      match_d     <= 1'b0;
      buzz        <= 1'b0;
      alarm_led   <= 1'b0;
      ringing     <= 1'b0;
    end else begin
      state       <= state_nxt;
      counter     <= counter_nxt;
      snooze_left <= snz_nxt;
      phase       <= phase_nxt;
      blink       <= blink_nxt;
      match_d     <= match;
      buzz        <= (state_nxt == RING) & phase_nxt;
      alarm_led   <= (state_nxt == RING) | ((state_nxt == SNOOZE) & blink_nxt);
      ringing     <= (state_nxt == RING);
    end
  end

endmodule
